// File: rtl/dbg_abs_cmd_if.sv
// Debugger register-access bus between the abstract command engine
// and the CSR / trigger / GPR responders.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CMD_REGNO_SIZE
`define CMD_REGNO_SIZE 16
`endif

interface dbg_abs_cmd_if;
   logic                       dbg_reg_access;
   logic                       dbg_wr1_rd0;
   logic [`CMD_REGNO_SIZE-1:0] dbg_regno;
   logic [`DATA_WIDTH-1:0]     dbg_write_data;
   logic [`DATA_WIDTH-1:0]     dbg_read_data;
   logic                       dbg_read_data_valid;
   logic                       dbg_wr;

   modport master (
      output dbg_reg_access, dbg_wr1_rd0, dbg_regno, dbg_write_data,
      input  dbg_read_data, dbg_read_data_valid, dbg_wr
   );

   modport slave (
      input  dbg_reg_access, dbg_wr1_rd0, dbg_regno, dbg_write_data,
      output dbg_read_data, dbg_read_data_valid, dbg_wr
   );
endinterface

// File: rtl/dbg_abs_cmd.sv
// Abstract command engine: validates Access Register commands and runs them
// on the responder bus. Optional data0 autoexec: define DBG_AUTOEXEC_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef CMD_REGNO_SIZE
`define CMD_REGNO_SIZE 16
`endif

module dbg_abs_cmd #(
   parameter int TIMEOUT = 8
) (
   input  logic                   cpu_clk,
   input  logic                   cpu_rstn,
   input  logic                   cmd_wr,
   input  logic [31:0]            cmd_wdata,
   input  logic                   data0_wr,
   input  logic                   data0_rd,
   input  logic [`DATA_WIDTH-1:0] data0_wdata,
   output logic [`DATA_WIDTH-1:0] data0,
   input  logic                   cmderr_wr,
   input  logic [2:0]             cmderr_w1c,
   output logic                   busy,
   output logic [2:0]             cmderr,
   input  logic                   dbg_mode,
   dbg_abs_cmd_if.master          dbg
);

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] ACCESS = 1'b1;

   logic [0:0]             state;
   logic [`DATA_WIDTH-1:0] data0_q;
   logic [2:0]             err_q;
   logic                   acc_q;
   logic                   wr_q;
   logic [31:0]            cmd_q;
   logic [7:0]             cnt;
   logic [2:0]             new_err;
   logic [31:0]            c;
   logic                   go;
   logic                   bad;
   logic                   done;
   logic                   last;
   logic                   host_hit;
   logic                   ae_go;
   logic                   ae_rd;
   logic                   unused_ok;

`ifdef DBG_AUTOEXEC_EN
   logic auto_q;

   // data0 touched while idle and error-free replays the stored command
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) auto_q <= 1'b0;
      else auto_q <= (state == IDLE) && (err_q == 3'd0) &&
                     (data0_rd || data0_wr);
   end

   assign ae_go = auto_q;
   assign ae_rd = data0_rd;
`else
   assign ae_go = 1'b0;
   assign ae_rd = 1'b0;
`endif

   assign go       = cmd_wr | ae_go;
   assign c        = cmd_wr ? cmd_wdata : cmd_q;
   assign bad      = (c[31:24] != 8'd0) || (c[22:20] != 3'd2) || c[18];
   assign done     = wr_q ? dbg.dbg_wr : dbg.dbg_read_data_valid;
   assign last     = (cnt == 8'(TIMEOUT - 1));
   assign host_hit = cmd_wr | data0_wr | ae_rd;
   assign unused_ok = ^{data0_rd, c[23]};

   // error raised this cycle; zero means none
   always_comb begin
      new_err = 3'd0;
      if (state == IDLE) begin
         if (go && err_q == 3'd0) begin
            if (bad) new_err = 3'd2;
            else if (c[17] && !dbg_mode) new_err = 3'd4;
         end
      end else begin
         if (!done && !dbg_mode) new_err = 3'd4;
         else if (!done && last) new_err = 3'd3;
         if (new_err == 3'd0 && host_hit && err_q == 3'd0)
            new_err = 3'd1;
      end
   end

   // command FSM, data0 staging and sticky error register
   always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
      if (!cpu_rstn) begin
         state   <= IDLE;
         data0_q <= '0;
         err_q   <= 3'd0;
         acc_q   <= 1'b0;
         wr_q    <= 1'b0;
         cmd_q   <= 32'd0;
         cnt     <= 8'd0;
      end else begin
         if (new_err != 3'd0) err_q <= new_err;
         else if (cmderr_wr) err_q <= err_q & ~cmderr_w1c;
         case (state)
            IDLE: begin
               if (data0_wr) data0_q <= data0_wdata;
               if (go && err_q == 3'd0 && !bad &&
                   !(c[17] && !dbg_mode)) begin
                  if (c[17]) begin
                     cmd_q <= c;
                     state <= ACCESS;
                     acc_q <= 1'b1;
                     wr_q  <= c[16];
                     cnt   <= 8'd0;
                  end else begin
                     cmd_q <= {c[31:16], c[15:0] + {15'd0, c[19]}};
                  end
               end
            end
            default: begin
               if (done) begin
                  if (!wr_q) data0_q <= dbg.dbg_read_data;
                  if (cmd_q[19]) cmd_q[15:0] <= cmd_q[15:0] + 16'd1;
                  state <= IDLE;
                  acc_q <= 1'b0;
               end else if (!dbg_mode || last) begin
                  state <= IDLE;
                  acc_q <= 1'b0;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
         endcase
      end
   end

   assign data0              = data0_q;
   assign busy               = (state == ACCESS);
   assign cmderr             = err_q;
   assign dbg.dbg_reg_access = acc_q;
   assign dbg.dbg_wr1_rd0    = wr_q;
   assign dbg.dbg_regno      = cmd_q[`CMD_REGNO_SIZE-1:0];
   assign dbg.dbg_write_data = data0_q;

endmodule

// File: tb/tb_dbg_abs_cmd.sv
// Self-checking bench for dbg_abs_cmd: directed scenarios plus a
// randomized command stream checked against a transaction-level model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_dbg_abs_cmd;
   logic        cpu_clk = 1'b0;
   logic        cpu_rstn = 1'b0;
   logic        cmd_wr = 1'b0;
   logic [31:0] cmd_wdata = 32'd0;
   logic        data0_wr = 1'b0;
   logic        data0_rd = 1'b0;
   logic [31:0] data0_wdata = 32'd0;
   logic [31:0] data0;
   logic        cmderr_wr = 1'b0;
   logic [2:0]  cmderr_w1c = 3'd0;
   logic        busy;
   logic [2:0]  cmderr;
   logic        dbg_mode = 1'b1;

   int tests_run = 0;
   int tests_failed = 0;
   logic [31:0] m_data0;
   logic [15:0] m_regno;

   dbg_abs_cmd_if bus ();

   dbg_abs_cmd #(.TIMEOUT(8)) dut (
      .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn),
      .cmd_wr(cmd_wr), .cmd_wdata(cmd_wdata),
      .data0_wr(data0_wr), .data0_rd(data0_rd),
      .data0_wdata(data0_wdata), .data0(data0),
      .cmderr_wr(cmderr_wr), .cmderr_w1c(cmderr_w1c),
      .busy(busy), .cmderr(cmderr), .dbg_mode(dbg_mode),
      .dbg(bus.master)
   );

   always #5 cpu_clk = ~cpu_clk;

   task automatic tick;
      @(posedge cpu_clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] c);
      cmd_wr = 1'b1; cmd_wdata = c;
      tick();
      cmd_wr = 1'b0;
   endtask

   task automatic clr;
      cmderr_wr = 1'b1; cmderr_w1c = 3'h7;
      tick();
      cmderr_wr = 1'b0; cmderr_w1c = 3'h0;
   endtask

   task automatic wr_data0(input logic [31:0] v);
      data0_wr = 1'b1; data0_wdata = v;
      tick();
      data0_wr = 1'b0;
   endtask

   task automatic resp_read(input logic [31:0] v);
      bus.dbg_read_data = v; bus.dbg_read_data_valid = 1'b1;
      tick();
      bus.dbg_read_data = 32'd0; bus.dbg_read_data_valid = 1'b0;
   endtask

   task automatic resp_write;
      bus.dbg_wr = 1'b1;
      tick();
      bus.dbg_wr = 1'b0;
   endtask

   function automatic logic [2:0] model_err(logic [31:0] c, logic mode);
      if (c[31:24] != 8'd0 || c[22:20] != 3'd2 || c[18]) return 3'd2;
      if (c[17] && !mode) return 3'd4;
      return 3'd0;
   endfunction

   task automatic test_reset;
      cpu_rstn = 1'b0;
      tick(); tick();
      cpu_rstn = 1'b1;
      tick();
      m_data0 = 32'd0; m_regno = 16'd0;
      tests_run++; if (data0 !== 32'd0) begin tests_failed++; $display("FAIL rst_data0: got %h want 0", data0); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b want 0", busy); end
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL rst_cmderr: got %0d want 0", cmderr); end
      tests_run++; if (bus.dbg_reg_access !== 1'b0) begin tests_failed++; $display("FAIL rst_access: got %b want 0", bus.dbg_reg_access); end
      tests_run++; if (bus.dbg_wr1_rd0 !== 1'b0) begin tests_failed++; $display("FAIL rst_wr1rd0: got %b want 0", bus.dbg_wr1_rd0); end
      tests_run++; if (bus.dbg_regno !== 16'd0) begin tests_failed++; $display("FAIL rst_regno: got %h want 0", bus.dbg_regno); end
   endtask

   task automatic test_halted_read;
      dbg_mode = 1'b1;
      issue(32'h0022_07B0);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL rd_busy: got %b want 1", busy); end
      tests_run++; if (bus.dbg_reg_access !== 1'b1) begin tests_failed++; $display("FAIL rd_access: got %b want 1", bus.dbg_reg_access); end
      tests_run++; if (bus.dbg_wr1_rd0 !== 1'b0) begin tests_failed++; $display("FAIL rd_dir: got %b want 0", bus.dbg_wr1_rd0); end
      tests_run++; if (bus.dbg_regno !== 16'h07B0) begin tests_failed++; $display("FAIL rd_regno: got %h want 07b0", bus.dbg_regno); end
      resp_read(32'hDEAD_BEEF);
      m_data0 = 32'hDEAD_BEEF; m_regno = 16'h07B0;
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL rd_data0: got %h want %h", data0, m_data0); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rd_done: got %b want 0", busy); end
      tests_run++; if (bus.dbg_reg_access !== 1'b0) begin tests_failed++; $display("FAIL rd_acc_off: got %b want 0", bus.dbg_reg_access); end
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL rd_err: got %0d want 0", cmderr); end
   endtask

   task automatic test_write_postinc;
      wr_data0(32'h0000_1234);
      m_data0 = 32'h1234;
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL wr_stage: got %h want %h", data0, m_data0); end
      issue(32'h002B_FFFF);
      tests_run++; if (bus.dbg_wr1_rd0 !== 1'b1) begin tests_failed++; $display("FAIL wr_dir: got %b want 1", bus.dbg_wr1_rd0); end
      tests_run++; if (bus.dbg_write_data !== 32'h1234) begin tests_failed++; $display("FAIL wr_wdata: got %h want 1234", bus.dbg_write_data); end
      tests_run++; if (bus.dbg_regno !== 16'hFFFF) begin tests_failed++; $display("FAIL wr_regno: got %h want ffff", bus.dbg_regno); end
      resp_write();
      m_regno = 16'h0000;
      tests_run++; if (bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL wr_wrap: got %h want %h", bus.dbg_regno, m_regno); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL wr_done: got %b want 0", busy); end
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL wr_data0: got %h want %h", data0, m_data0); end
   endtask

   task automatic test_errors;
      issue(32'h0032_0000);
      tests_run++; if (cmderr !== 3'd2) begin tests_failed++; $display("FAIL err_size: got %0d want 2", cmderr); end
      tests_run++; if (bus.dbg_reg_access !== 1'b0) begin tests_failed++; $display("FAIL err_size_acc: got %b want 0", bus.dbg_reg_access); end
      issue(32'h0022_0005);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL err_block: got %b want 0", busy); end
      tests_run++; if (cmderr !== 3'd2) begin tests_failed++; $display("FAIL err_sticky: got %0d want 2", cmderr); end
      clr();
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL err_clr2: got %0d want 0", cmderr); end
      issue(32'h0126_0000);
      tests_run++; if (cmderr !== 3'd2) begin tests_failed++; $display("FAIL err_type: got %0d want 2", cmderr); end
      clr();
      dbg_mode = 1'b0;
      issue(32'h0022_1000);
      dbg_mode = 1'b1;
      tests_run++; if (cmderr !== 3'd4) begin tests_failed++; $display("FAIL err_mode: got %0d want 4", cmderr); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL err_mode_busy: got %b want 0", busy); end
      clr();
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL err_clr4: got %0d want 0", cmderr); end
      issue(32'h0022_0006);
      issue(32'h0022_0007);
      tests_run++; if (cmderr !== 3'd1) begin tests_failed++; $display("FAIL err_busy: got %0d want 1", cmderr); end
      tests_run++; if (bus.dbg_regno !== 16'h0006) begin tests_failed++; $display("FAIL err_busy_regno: got %h want 0006", bus.dbg_regno); end
      wr_data0(32'h5555_5555);
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL err_busy_d0: got %h want %h", data0, m_data0); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL err_busy_run: got %b want 1", busy); end
      resp_read(32'h0000_0077);
      m_data0 = 32'h77; m_regno = 16'h0006;
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL err_busy_fin: got %h want %h", data0, m_data0); end
      clr();
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL err_clr1: got %0d want 0", cmderr); end
   endtask

   task automatic test_timeout;
      issue(32'h0022_0042);
      m_regno = 16'h0042;
      for (int i = 0; i < 8; i++) begin
         tests_run++; if (bus.dbg_reg_access !== 1'b1) begin tests_failed++; $display("FAIL to_acc%0d: got %b want 1", i, bus.dbg_reg_access); end
         tick();
      end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b want 0", busy); end
      tests_run++; if (cmderr !== 3'd3) begin tests_failed++; $display("FAIL to_err: got %0d want 3", cmderr); end
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL to_data0: got %h want %h", data0, m_data0); end
      clr();
   endtask

   task automatic test_mode_abort;
      issue(32'h002A_0010);
      tick();
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ab_busy: got %b want 1", busy); end
      dbg_mode = 1'b0;
      tick();
      dbg_mode = 1'b1;
      m_regno = 16'h0010;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL ab_idle: got %b want 0", busy); end
      tests_run++; if (cmderr !== 3'd4) begin tests_failed++; $display("FAIL ab_err: got %0d want 4", cmderr); end
      tests_run++; if (bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL ab_regno: got %h want %h", bus.dbg_regno, m_regno); end
      tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL ab_data0: got %h want %h", data0, m_data0); end
      clr();
   endtask

   task automatic test_back_to_back;
      issue(32'h0022_0100);
      resp_read(32'hA5A5_0001);
      m_data0 = 32'hA5A5_0001;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_idle: got %b want 0", busy); end
      issue(32'h0023_0200);
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL b2b_busy: got %b want 1", busy); end
      tests_run++; if (bus.dbg_write_data !== m_data0) begin tests_failed++; $display("FAIL b2b_wdata: got %h want %h", bus.dbg_write_data, m_data0); end
      tests_run++; if (bus.dbg_regno !== 16'h0200) begin tests_failed++; $display("FAIL b2b_regno: got %h want 0200", bus.dbg_regno); end
      resp_write();
      m_regno = 16'h0200;
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL b2b_err: got %0d want 0", cmderr); end
   endtask

`ifdef DBG_AUTOEXEC_EN
   task automatic test_autoexec;
      issue(32'h002A_1000);
      resp_read(32'h1000);
      m_data0 = 32'h1000;
      for (int i = 1; i <= 3; i++) begin
         data0_rd = 1'b1;
         tick();
         data0_rd = 1'b0;
         tick();
         tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL ae_busy%0d: got %b want 1", i, busy); end
         tests_run++; if (bus.dbg_regno !== 16'(16'h1000 + i)) begin tests_failed++; $display("FAIL ae_regno%0d: got %h want %h", i, bus.dbg_regno, 16'(16'h1000 + i)); end
         resp_read(32'h1000 + i);
         m_data0 = 32'h1000 + i;
      end
      m_regno = 16'h1004;
      tests_run++; if (bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL ae_final: got %h want %h", bus.dbg_regno, m_regno); end
      tests_run++; if (cmderr !== 3'd0) begin tests_failed++; $display("FAIL ae_err: got %0d want 0", cmderr); end
   endtask
`endif

   task automatic test_reset_mid;
      issue(32'h0022_0300);
      tick();
      cpu_rstn = 1'b0;
      #1;
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rm_busy: got %b want 0", busy); end
      tests_run++; if (bus.dbg_reg_access !== 1'b0) begin tests_failed++; $display("FAIL rm_acc: got %b want 0", bus.dbg_reg_access); end
      tests_run++; if (data0 !== 32'd0) begin tests_failed++; $display("FAIL rm_data0: got %h want 0", data0); end
      cpu_rstn = 1'b1;
      tick();
      m_data0 = 32'd0; m_regno = 16'd0;
   endtask

   task automatic test_random;
      logic [31:0] c, rv;
      logic [7:0]  ct;
      logic [2:0]  sz, e;
      logic        mode;
      int          d;
      for (int it = 0; it < 60; it++) begin
         ct = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
         sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         c = {ct, 1'b0, sz, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 7) == 0), 1'b1,
              1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom)};
         mode = ($urandom_range(0, 5) != 0);
         if ($urandom_range(0, 1) == 1) begin
            rv = $urandom;
            wr_data0(rv);
            m_data0 = rv;
         end
         dbg_mode = mode;
         issue(c);
         dbg_mode = 1'b1;
         e = model_err(c, mode);
         if (e != 3'd0) begin
            tests_run++; if (cmderr !== e || busy !== 1'b0) begin tests_failed++; $display("FAIL rnd_err%0d: got %0d/%b want %0d/0", it, cmderr, busy, e); end
            tests_run++; if (bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL rnd_eregno%0d: got %h want %h", it, bus.dbg_regno, m_regno); end
            clr();
         end else begin
            m_regno = c[15:0];
            tests_run++; if (busy !== 1'b1 || bus.dbg_wr1_rd0 !== c[16] || bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL rnd_req%0d: got %b/%b/%h want 1/%b/%h", it, busy, bus.dbg_wr1_rd0, bus.dbg_regno, c[16], m_regno); end
            if (c[16]) begin
               tests_run++; if (bus.dbg_write_data !== m_data0) begin tests_failed++; $display("FAIL rnd_wdata%0d: got %h want %h", it, bus.dbg_write_data, m_data0); end
            end
            d = $urandom_range(0, 9);
            for (int k = 0; k < d && k < 8; k++) tick();
            if (d < 8) begin
               rv = $urandom;
               if (c[16]) resp_write();
               else begin
                  resp_read(rv);
                  m_data0 = rv;
               end
               if (c[19]) m_regno = m_regno + 16'd1;
               e = 3'd0;
            end else begin
               e = 3'd3;
            end
            tests_run++; if (busy !== 1'b0 || cmderr !== e) begin tests_failed++; $display("FAIL rnd_end%0d: got %b/%0d want 0/%0d", it, busy, cmderr, e); end
            tests_run++; if (data0 !== m_data0) begin tests_failed++; $display("FAIL rnd_data0_%0d: got %h want %h", it, data0, m_data0); end
            tests_run++; if (bus.dbg_regno !== m_regno) begin tests_failed++; $display("FAIL rnd_regno%0d: got %h want %h", it, bus.dbg_regno, m_regno); end
            if (e != 3'd0) clr();
         end
      end
   endtask

   initial begin
      bus.dbg_read_data = 32'd0;
      bus.dbg_read_data_valid = 1'b0;
      bus.dbg_wr = 1'b0;
      test_reset();
      test_halted_read();
      test_write_postinc();
      test_errors();
      test_timeout();
      test_mode_abort();
      test_back_to_back();
`ifdef DBG_AUTOEXEC_EN
      test_autoexec();
`endif
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
